// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues in-order word fetches, buffers returned words
// in a small FIFO and presents {instruction, pc} to decode; redirects flush it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      head_pc_q, head_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      fifo_mem_q [FIFO_DEPTH];

  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           push;
  logic           pop;
  logic [31:0]    target_pc;

  // Handshakes: a transfer happens in exactly the cycle where valid and ready
  // are both high; a valid source holds its payload stable until that cycle.
  assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid       = !rst && (count_q != '0) && !redirect_valid;
  assign id_instruction = fifo_mem_q[rd_ptr_q];
  assign id_pc          = head_pc_q;
  assign pop            = id_valid && id_ready;

  // Responses owed to a pre-redirect request are counted off by discard_q.
  assign push      = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      head_pc_d  = target_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = inflight_q - CNT_W'(imem_rsp_valid);
      discard_d  = inflight_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        head_pc_d = head_pc_q + 32'd4;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based program-order model of the fetch stage.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mreq_t;

  // scoreboard: {pc, word} expected at ID, oldest first
  logic [63:0] exp_q[$];
  pend_t       pend_m[$];
  mreq_t       mem_q[$];
  logic [31:0] fpc_m;

  int vectors;
  int miscompares;
  int cyc;

  logic        rst_s, redir_s, idr_s, rqr_s;
  logic [31:0] rpc_s;
  int          rsp_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver + model step for one clock
  task automatic cycle();
    logic  exp_rv, exp_iv, fire;
    pend_t p;
    logic [31:0] a;

    rst            = rst_s;
    redirect_valid = redir_s;
    redirect_pc    = rpc_s;
    id_ready       = idr_s;
    imem_req_ready = rqr_s;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst_s && mem_q.size() > 0 && mem_q[0].cyc < cyc &&
        $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end
    #3;

    exp_rv = !rst_s && !redir_s && (exp_q.size() + pend_m.size() < DEPTH);
    exp_iv = !rst_s && !redir_s && (exp_q.size() > 0);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, fpc_m);
    check("id_valid", 32'(id_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("id_pc", id_pc, exp_q[0][63:32]);
      check("id_instr", id_instruction, exp_q[0][31:0]);
    end

    // memory side follows what the DUT actually does
    fire = imem_req_valid && imem_req_ready && !rst_s;
    if (rst_s) mem_q.delete();
    else begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (fire) mem_q.push_back('{addr: imem_req_addr, cyc: cyc});
    end

    // reference model
    if (rst_s) begin
      exp_q.delete();
      pend_m.delete();
      fpc_m = RESET_PC;
    end else begin
      if (imem_rsp_valid) begin
        check("rsp_has_inflight", 32'(pend_m.size() != 0), 32'd1);
        if (pend_m.size() != 0) begin
          p = pend_m.pop_front();
          if (!redir_s && !p.stale) exp_q.push_back({p.addr, mem_word(p.addr)});
        end
      end
      if (redir_s) begin
        exp_q.delete();
        foreach (pend_m[i]) pend_m[i].stale = 1'b1;
        fpc_m = rpc_s & 32'hFFFF_FFFC;
      end else begin
        if (exp_iv && idr_s) void'(exp_q.pop_front());
        if (exp_rv && rqr_s) begin
          a = fpc_m;
          pend_m.push_back('{addr: a, stale: 1'b0});
          fpc_m = fpc_m + 32'd4;
        end
      end
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    fpc_m = RESET_PC;
    rst_s = 1'b1; redir_s = 1'b0; idr_s = 1'b0; rqr_s = 1'b0; rpc_s = '0; rsp_pct = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk); #1;

    // 1: reset then streaming fetch with latency-1 memory
    repeat (2) cycle();
    rst_s = 1'b0; idr_s = 1'b1; rqr_s = 1'b1; rsp_pct = 100;
    repeat (8) cycle();

    // 2: decode stalled until buffer and credits are exhausted, then released
    idr_s = 1'b0;
    repeat (6) cycle();
    idr_s = 1'b1;
    repeat (6) cycle();

    // 3: memory refuses requests for three cycles
    rqr_s = 1'b0;
    repeat (3) cycle();
    rqr_s = 1'b1;
    repeat (4) cycle();

    // 4: two requests outstanding when a redirect to 0x100 arrives
    rqr_s = 1'b0; idr_s = 1'b1;
    repeat (4) cycle();
    rqr_s = 1'b1; idr_s = 1'b0; rsp_pct = 0;
    repeat (3) cycle();
    redir_s = 1'b1; rpc_s = 32'h0000_0100;
    cycle();
    redir_s = 1'b0; idr_s = 1'b1; rsp_pct = 100;
    repeat (8) cycle();

    // 5: misaligned redirect with a response landing in the same cycle
    rqr_s = 1'b0;
    repeat (4) cycle();
    rqr_s = 1'b1; idr_s = 1'b0; rsp_pct = 0;
    repeat (3) cycle();
    redir_s = 1'b1; rpc_s = 32'h0000_0103; rsp_pct = 100;
    cycle();
    redir_s = 1'b0; idr_s = 1'b1;
    repeat (8) cycle();

    // 6: reset while the buffer is full
    idr_s = 1'b0;
    repeat (6) cycle();
    rst_s = 1'b1;
    cycle();
    rst_s = 1'b0; idr_s = 1'b1;
    repeat (6) cycle();

    // address wrap and back-to-back redirects
    redir_s = 1'b1; rpc_s = 32'hFFFF_FFF9;
    cycle();
    rpc_s = 32'hFFFF_FFF6;
    cycle();
    redir_s = 1'b0;
    repeat (10) cycle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_s   = ($urandom_range(199) == 0);
      redir_s = ($urandom_range(19) == 0);
      rpc_s   = $urandom;
      if ($urandom_range(3) == 0) rpc_s = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      idr_s   = ($urandom_range(9) < 7);
      rqr_s   = ($urandom_range(9) < 7);
      rsp_pct = 60;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
